// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch -- RV32I instruction fetch unit.
//
// Owns the program counter, issues word-aligned read requests to instruction
// memory, buffers returned words tagged with their PC, and hands them to
// decode over a valid/ready handshake. A redirect from execute flushes the
// buffer, restarts fetch at the new PC and drops every response still owed
// for requests granted at or before the redirect cycle.
//
// Ports
//   i_clock, i_reset_n           clock (rising edge), async active-low reset
//   o_imem_req / o_imem_addr     fetch request and word-aligned address
//   i_imem_gnt                   request accepted this cycle
//   i_imem_rvalid / i_imem_rdata in-order response, >=1 cycle after grant
//   i_redirect / i_redirect_pc   flush and restart at new PC (bits [1:0] forced 0)
//   o_valid / i_ready            decode handshake
//   o_instruction / o_pc         FIFO head (NOP / 0 when empty)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// ifetch_fifo -- {pc, instruction} buffer, DEPTH a power of two.
//   i_flush clears the buffer and wins over a same-cycle push/pop.
//   o_cnt is exposed so the fetch side can bound outstanding requests.
// ---------------------------------------------------------------------------
module ifetch_fifo #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       i_clock,
  input  logic                       i_reset_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [W-1:0]               i_wdata,
  input  logic                       i_pop,
  output logic [W-1:0]               o_rdata,
  output logic [$clog2(DEPTH):0]     o_cnt
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [PW-1:0]           rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (i_flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      // pointers wrap naturally since DEPTH is a power of two
      if (i_push) wr_d = wr_q + PW'(1);
      if (i_pop)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // storage needs no reset: contents are only visible while cnt_q != 0
  always_ff @(posedge i_clock) begin
    if (i_push && !i_flush) mem_q[wr_q] <= i_wdata;
  end

  assign o_rdata = mem_q[rd_q];
  assign o_cnt   = cnt_q;
endmodule

module ifetch #(
  parameter int unsigned        NB_WORD    = 32,
  parameter int unsigned        NB_ADDR    = 32,
  parameter logic [NB_ADDR-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned        FIFO_DEPTH = 2
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  output logic               o_imem_req,
  output logic [NB_ADDR-1:0] o_imem_addr,
  input  logic               i_imem_gnt,
  input  logic               i_imem_rvalid,
  input  logic [NB_WORD-1:0] i_imem_rdata,
  input  logic               i_redirect,
  input  logic [NB_ADDR-1:0] i_redirect_pc,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_WORD-1:0] o_instruction,
  output logic [NB_ADDR-1:0] o_pc
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;   // 0..FIFO_DEPTH
  localparam int unsigned DW = PW + 2;   // 0..2*FIFO_DEPTH
  localparam logic [CW:0]        OCC_MAX  = (CW+1)'(FIFO_DEPTH);
  localparam logic [NB_WORD-1:0] NOP      = NB_WORD'(32'h0000_0013);
  localparam logic [NB_ADDR-1:0] PC_STEP  = NB_ADDR'(4);
  localparam logic [NB_ADDR-1:0] RST_PC_A = {RESET_PC[NB_ADDR-1:2], 2'b00};

  typedef struct packed {
    logic [NB_ADDR-1:0] pc;
    logic [NB_WORD-1:0] insn;
  } entry_t;

  logic [NB_ADDR-1:0] fetch_pc_q, fetch_pc_d;
  logic [NB_ADDR-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]      live_q, live_d;
  logic [DW-1:0]      disc_q, disc_d;
  // low in reset, set on the first edge after release; keeps o_imem_req a
  // function of registered state while still holding it low during reset
  logic               run_q;

  logic [CW-1:0]      fifo_cnt;
  entry_t             head, wentry;
  logic [CW:0]        occ;
  logic               gnt, drop, take, push, pop;
  logic [NB_ADDR-1:0] redir_pc;

  assign redir_pc = {i_redirect_pc[NB_ADDR-1:2], 2'b00};

  // Live requests plus buffered entries never exceed the FIFO, so a granted
  // request always has a slot waiting for its response.
  assign occ        = {1'b0, live_q} + {1'b0, fifo_cnt};
  assign o_imem_req = run_q & (disc_q == '0) & (occ < OCC_MAX);
  assign o_imem_addr = fetch_pc_q;

  assign gnt  = o_imem_req & i_imem_gnt;
  assign drop = i_imem_rvalid & (disc_q != '0);
  assign take = i_imem_rvalid & (disc_q == '0);
  // a response landing in the redirect cycle belongs to the old stream
  assign push = take & ~i_redirect;
  assign pop  = o_valid & i_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    live_d     = live_q;
    disc_d     = disc_q;
    if (i_redirect) begin
      fetch_pc_d = redir_pc;
      resp_pc_d  = redir_pc;
      // everything still owed (including this cycle's grant) becomes discard,
      // minus the response consumed this cycle, whichever counter it came from
      disc_d     = disc_q + DW'(live_q) + DW'(gnt) - DW'(i_imem_rvalid);
      live_d     = '0;
    end else begin
      if (gnt)  fetch_pc_d = fetch_pc_q + PC_STEP;
      if (push) resp_pc_d  = resp_pc_q + PC_STEP;
      if (drop) disc_d     = disc_q - DW'(1);
      live_d = live_q + CW'(gnt) - CW'(take);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fetch_pc_q <= RST_PC_A;
      resp_pc_q  <= RST_PC_A;
      live_q     <= '0;
      disc_q     <= '0;
      run_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      live_q     <= live_d;
      disc_q     <= disc_d;
      run_q      <= 1'b1;
    end
  end

  assign wentry.pc   = resp_pc_q;
  assign wentry.insn = i_imem_rdata;

  ifetch_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_flush   (i_redirect),
    .i_push    (push),
    .i_wdata   (wentry),
    .i_pop     (pop),
    .o_rdata   (head),
    .o_cnt     (fifo_cnt)
  );

  assign o_valid       = (fifo_cnt != '0) & ~i_redirect;
  assign o_instruction = (fifo_cnt != '0) ? head.insn : NOP;
  assign o_pc          = (fifo_cnt != '0) ? head.pc   : '0;
endmodule
